// File: rtl/pc_sequencer.sv
// Next-PC select and pipeline-advance control for the 5-stage pipeline.
// Chooses sequential/branch/jump PC, generates IF/ID write/flush, ID/EX bubble
// and a global freeze while a data-memory access is outstanding, and keeps
// run/stall cycle counters.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | machine stopped; pipeline frozen, counters hold
// RUN     | normal issue; redirects and load-use bubbles handled here
// MEMWAIT | data-memory access outstanding; whole pipeline frozen
module pc_sequencer #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [31:0]      pc_i,
   input  logic             branch_i,
   input  logic [31:0]      branch_target_i,
   input  logic             jump_i,
   input  logic [31:0]      jump_target_i,
   input  logic             idex_memread_i,
   input  logic [4:0]       idex_rt_i,
   input  logic [4:0]       ifid_rs_i,
   input  logic [4:0]       ifid_rt_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic [31:0]      pc_next_o,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             pipe_stall_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      MEMWAIT = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic mem_wait;
   logic load_use;
   logic active;

   assign active   = (state == RUN) || (state == MEMWAIT);
   assign mem_wait = ((state == RUN) && mem_req_i && !mem_ack_i) ||
                     ((state == MEMWAIT) && !mem_ack_i);
   // x0 is never a real destination, so a load into it cannot create a hazard.
   assign load_use = idex_memread_i && (idex_rt_i != 5'd0) &&
                     ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

   // State register; synchronous reset abandons any outstanding memory wait.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; dropping start_i wins over the memory handshake.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_i) state_nxt = RUN;
         end
         RUN: begin
            if (!start_i)                    state_nxt = IDLE;
            else if (mem_req_i && !mem_ack_i) state_nxt = MEMWAIT;
         end
         MEMWAIT: begin
            if (!start_i)      state_nxt = IDLE;
            else if (mem_ack_i) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Next-PC select is always visible, even when the PC write is suppressed.
   always_comb begin
      pc_next_o = pc_i + 32'd4;
      if (jump_i)        pc_next_o = jump_target_i;
      else if (branch_i) pc_next_o = branch_target_i;
   end

   // Pipeline control in priority order: stopped, memory freeze, load-use, issue.
   always_comb begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_stall_o  = 1'b0;
      if (!active || !start_i) begin
         pipe_stall_o = 1'b1;
      end else if (mem_wait) begin
         pipe_stall_o = 1'b1;
      end else if (load_use) begin
         idex_bubble_o = 1'b1;
      end else begin
         pc_write_o   = 1'b1;
         ifid_write_o = 1'b1;
         ifid_flush_o = jump_i || branch_i;
      end
   end

   // Saturating performance counters; they only advance while RUN or MEMWAIT.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cycle_cnt_o <= '0;
         stall_cnt_o <= '0;
      end else if (active) begin
         if (cycle_cnt_o != '1) cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
         if (!pc_write_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC and pipeline-advance controller for the 5-stage pipelined CPU. It selects the next PC (sequential, branch, or jump) and drives PC.PCWrite_i. It also generates IF/ID write and flush, ID/EX bubble, and a global freeze during multi-cycle data-memory accesses. It keeps run and stall cycle counters for performance checks. It sits between the ID-stage branch/jump logic, the hazard comparators and the data-memory handshake on one side, and the PC register plus pipeline registers on the other.

## Interface
- CNT_W, 32, width of the performance counters.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  run enable; low freezes the machine.
- pc_i  in  32  current PC (PC register output).
- branch_i  in  1  branch taken, resolved in ID.
- branch_target_i  in  32  branch target.
- jump_i  in  1  jump decoded in ID.
- jump_target_i  in  32  jump target.
- idex_memread_i  in  1  instruction in EX is a load.
- idex_rt_i  in  5  load destination register in EX.
- ifid_rs_i, ifid_rt_i  in  5 each  source registers of the instruction in ID.
- mem_req_i  in  1  instruction in MEM accesses data memory.
- mem_ack_i  in  1  data memory completes this cycle.
- pc_next_o  out  32  value written into PC.
- pc_write_o  out  1  PC write enable.
- ifid_write_o  out  1  IF/ID write enable.
- ifid_flush_o  out  1  zero IF/ID (squash fetched instruction).
- idex_bubble_o  out  1  zero ID/EX control fields.
- pipe_stall_o  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- cycle_cnt_o  out  CNT_W  cycles spent in RUN or MEMWAIT.
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0 while in RUN or MEMWAIT.

## Operation
- States: IDLE, RUN, MEMWAIT. Reset state is IDLE.
- Transitions:
  - IDLE goes to RUN when start_i=1.
  - RUN or MEMWAIT goes to IDLE when start_i=0. This takes priority over all other transitions.
  - RUN goes to MEMWAIT when mem_req_i=1 and mem_ack_i=0.
  - MEMWAIT goes to RUN when mem_ack_i=1.
- "Freeze" means all of the following: pc_write_o=0, ifid_write_o=0, pipe_stall_o=1, ifid_flush_o=0, idex_bubble_o=0.
- Control outputs are combinational from the current state and inputs, evaluated in this priority order:
  1. IDLE, or start_i=0: all control outputs 0, except pipe_stall_o=1.
  2. Memory wait: freeze. This applies in RUN when mem_req_i=1 and mem_ack_i=0, and in MEMWAIT when mem_ack_i=0.
  3. Load-use hazard: idex_memread_i=1, idex_rt_i≠0, and idex_rt_i equals ifid_rs_i or ifid_rt_i.
     - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0, pipe_stall_o=0.
     - Any branch or jump is ignored this cycle; it is re-evaluated next cycle.
  4. jump_i=1: pc_next_o=jump_target_i, pc_write_o=1, ifid_write_o=1, ifid_flush_o=1.
  5. branch_i=1: pc_next_o=branch_target_i, pc_write_o=1, ifid_write_o=1, ifid_flush_o=1.
  6. Otherwise: pc_next_o=pc_i+4 (wraps modulo 2^32), pc_write_o=1, ifid_write_o=1.
- The MEMWAIT cycle with mem_ack_i=1 is a release cycle and follows rules 3–6.
- pc_next_o always shows the rule 4–6 selection, even when pc_write_o=0.
- Counters:
  - cycle_cnt_o increments on every cycle spent in RUN or MEMWAIT.
  - stall_cnt_o increments on those same cycles when pc_write_o=0.
  - Both saturate at all-ones, are 0 at reset, and hold their value in IDLE.

## Timing
- Reset values: state IDLE, both counters 0. Control outputs are therefore all 0 except pipe_stall_o=1; pc_next_o=pc_i+4.
- rst_i overrides start_i in the same cycle.
- Reset asserted in MEMWAIT returns the block to IDLE. The outstanding memory transfer is abandoned.
- start_i rising at edge N makes the state RUN after N. The first PC write therefore happens at edge N+1.
- A zero-wait access (mem_req_i=1 and mem_ack_i=1 in the same RUN cycle) causes no freeze.
- A k-wait access produces k freeze cycles, then one release cycle. mem_req_i stays high throughout because the MEM stage is frozen.
- A redirect costs exactly one flushed slot. A load-use hazard costs exactly one bubble.

## Test plan
- Reset, then start_i=1 with pc_i=0 and no hazards: pc_next_o=4 from the first RUN cycle; cycle_cnt_o=3 after 3 RUN cycles; stall_cnt_o=0.
- jump_i=1, jump_target_i=0x40, branch_i=1 in the same cycle: pc_next_o=0x40, ifid_flush_o=1 for one cycle.
- idex_memread_i=1, idex_rt_i=5, ifid_rs_i=5, branch_i=1: one cycle with pc_write_o=0 and idex_bubble_o=1 and no flush. Next cycle, with the hazard cleared: redirect to branch_target_i.
- Same compare with idex_rt_i=0: no stall.
- mem_req_i=1 with mem_ack_i low for 3 cycles, then high: 3 freeze cycles (pipe_stall_o=1), state returns to RUN, stall_cnt_o=3.
- rst_i=1 in MEMWAIT: state IDLE next cycle, counters 0. pc_i=0xFFFFFFFC in RUN: pc_next_o=0.
